// File: rtl/arm_pkg.sv
// Shared types and constants for the ARM pipeline control path: forwarding
// select encodings, the SRAM wait FSM states and the NOP control word.
package arm_pkg;

    localparam logic [1:0] FWD_REG = 2'd0;
    localparam logic [1:0] FWD_MEM = 2'd1;
    localparam logic [1:0] FWD_WB  = 2'd2;

    typedef enum logic [1:0] {M_IDLE, M_WAIT, M_DONE} mem_state_t;

    typedef struct packed {
        logic       wb_en;
        logic       mem_read;
        logic       mem_write;
        logic [3:0] exe_cmd;
        logic       s_bit;
        logic       branch;
    } ctrl_word_t;

    // Loaded into ID/EXE when id_bubble is high.
    localparam ctrl_word_t NOP_CTRL = '0;

endpackage

// File: rtl/arm_pipe_ctrl_if.sv
// Hazard/stall signals exchanged between the core stages (master) and the
// pipeline control unit (slave).
interface arm_pipe_ctrl_if;
    logic [3:0] id_src1;
    logic [3:0] id_src2;
    logic       id_two_src;
    logic       id_uses_src1;
    logic [3:0] exe_dest;
    logic       exe_wb_en;
    logic       exe_mem_read;
    logic [3:0] mem_dest;
    logic       mem_wb_en;
    logic       mem_req;
    logic       sram_ready;
    logic       branch_taken;
    logic       freeze_front;
    logic       id_bubble;
    logic       flush_front;
    logic       freeze_all;
    logic [1:0] fwd_sel1;
    logic [1:0] fwd_sel2;

    modport master (
        output id_src1, id_src2, id_two_src, id_uses_src1, exe_dest, exe_wb_en,
               exe_mem_read, mem_dest, mem_wb_en, mem_req, sram_ready, branch_taken,
        input  freeze_front, id_bubble, flush_front, freeze_all, fwd_sel1, fwd_sel2
    );

    modport slave (
        input  id_src1, id_src2, id_two_src, id_uses_src1, exe_dest, exe_wb_en,
               exe_mem_read, mem_dest, mem_wb_en, mem_req, sram_ready, branch_taken,
        output freeze_front, id_bubble, flush_front, freeze_all, fwd_sel1, fwd_sel2
    );
endinterface

// File: rtl/arm_hazard_detect.sv
// Combinational source/dest compare for the ID instruction.
// ARM_FORWARDING_EN: only load-use counts as a hazard; otherwise any RAW match.
module arm_hazard_detect (
    input  logic [3:0] id_src1,
    input  logic [3:0] id_src2,
    input  logic       id_two_src,
    input  logic       id_uses_src1,
    input  logic [3:0] exe_dest,
    input  logic       exe_wb_en,
    input  logic       exe_mem_read,
    input  logic [3:0] mem_dest,
    input  logic       mem_wb_en,
    output logic       hazard,
    output logic       exe_match1,
    output logic       exe_match2,
    output logic       mem_match1,
    output logic       mem_match2
);
`ifdef ARM_FORWARDING_EN
    localparam bit FWD_ON = 1'b1;
`else
    localparam bit FWD_ON = 1'b0;
`endif

    logic load_use;
    logic any_match;

    always_comb begin
        exe_match1 = id_uses_src1 && exe_wb_en && (id_src1 == exe_dest);
        exe_match2 = id_two_src   && exe_wb_en && (id_src2 == exe_dest);
        mem_match1 = id_uses_src1 && mem_wb_en && (id_src1 == mem_dest);
        mem_match2 = id_two_src   && mem_wb_en && (id_src2 == mem_dest);
        // A load's result is not available for forwarding until it leaves MEM.
        load_use   = exe_mem_read && (exe_match1 || exe_match2);
        any_match  = exe_match1 || exe_match2 || mem_match1 || mem_match2;
        hazard     = load_use || (!FWD_ON && any_match);
    end
endmodule

// File: rtl/arm_pipe_ctrl.sv
// Pipeline control unit: freeze/flush/bubble from RAW hazards, taken branches
// and SRAM wait states; forwarding selects when ARM_FORWARDING_EN is defined.
module arm_pipe_ctrl
    import arm_pkg::*;
#(
    parameter int MEM_WAIT  = 4,
    parameter int USE_READY = 0,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    arm_pipe_ctrl_if.slave   pif,
    output logic [CNT_W-1:0] stall_cnt
);
`ifdef ARM_FORWARDING_EN
    localparam bit FWD_ON = 1'b1;
`else
    localparam bit FWD_ON = 1'b0;
`endif

    mem_state_t       state_q, state_d;
    logic [3:0]       wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic             frz_mem, mem_done;
    logic             hazard, exe_match1, exe_match2, mem_match1, mem_match2;
    logic [1:0]       fsel1, fsel2;

    arm_hazard_detect u_hd (
        .id_src1      (pif.id_src1),
        .id_src2      (pif.id_src2),
        .id_two_src   (pif.id_two_src),
        .id_uses_src1 (pif.id_uses_src1),
        .exe_dest     (pif.exe_dest),
        .exe_wb_en    (pif.exe_wb_en),
        .exe_mem_read (pif.exe_mem_read),
        .mem_dest     (pif.mem_dest),
        .mem_wb_en    (pif.mem_wb_en),
        .hazard       (hazard),
        .exe_match1   (exe_match1),
        .exe_match2   (exe_match2),
        .mem_match1   (mem_match1),
        .mem_match2   (mem_match2)
    );

    // The trigger cycle in M_IDLE is freeze cycle 0, so M_WAIT starts at count 1.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        frz_mem    = 1'b0;
        mem_done   = (USE_READY != 0) ? pif.sram_ready : (wait_cnt_q == 4'(MEM_WAIT - 1));
        case (state_q)
            M_IDLE: if (pif.mem_req) begin
                frz_mem    = 1'b1;
                wait_cnt_d = 4'd1;
                state_d    = (USE_READY == 0 && MEM_WAIT == 1) ? M_DONE : M_WAIT;
            end
            M_WAIT: begin
                frz_mem    = 1'b1;
                wait_cnt_d = wait_cnt_q + 4'd1;
                if (mem_done) state_d = M_DONE;
            end
            M_DONE:  state_d = M_IDLE;
            default: state_d = M_IDLE;
        endcase
    end

    // MEM priority over WB: the EXE result is the younger write.
    always_comb begin
        fsel1 = exe_match1 ? FWD_MEM : (mem_match1 ? FWD_WB : FWD_REG);
        fsel2 = exe_match2 ? FWD_MEM : (mem_match2 ? FWD_WB : FWD_REG);
    end

    assign pif.freeze_all   = rst && frz_mem;
    assign pif.flush_front  = rst && !frz_mem && pif.branch_taken;
    assign pif.freeze_front = rst && !frz_mem && !pif.branch_taken && hazard;
    assign pif.id_bubble    = rst && !frz_mem && !pif.branch_taken && hazard;
    assign pif.fwd_sel1     = (rst && FWD_ON) ? fsel1 : FWD_REG;
    assign pif.fwd_sel2     = (rst && FWD_ON) ? fsel2 : FWD_REG;
    assign stall_cnt        = rst ? stall_cnt_q : '0;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if ((pif.freeze_all || pif.freeze_front) && stall_cnt_q != '1)
            stall_cnt_d = stall_cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= M_IDLE;
            wait_cnt_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end
endmodule

// File: tb/tb_arm_pipe_ctrl.sv
// Directed bench for arm_pipe_ctrl (MEM_WAIT=4, USE_READY=0); expectations
// follow ARM_FORWARDING_EN when it is defined for the build.
module tb_arm_pipe_ctrl;
`ifdef ARM_FORWARDING_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] stall_cnt;
    int          n_vec = 0;
    int          n_err = 0;

    arm_pipe_ctrl_if pif ();

    arm_pipe_ctrl #(.MEM_WAIT(4), .USE_READY(0), .CNT_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .pif       (pif),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #2;
    endtask

    task automatic clr;
        pif.id_src1 = 4'd0;  pif.id_src2 = 4'd0;  pif.id_two_src = 1'b0;
        pif.id_uses_src1 = 1'b0;  pif.exe_dest = 4'd0;  pif.exe_wb_en = 1'b0;
        pif.exe_mem_read = 1'b0;  pif.mem_dest = 4'd0;  pif.mem_wb_en = 1'b0;
        pif.mem_req = 1'b0;  pif.sram_ready = 1'b0;  pif.branch_taken = 1'b0;
    endtask

    task automatic chk_front(input string tag, input logic frz, input logic flush);
        chk({tag, ".freeze_front"}, pif.freeze_front, frz);
        chk({tag, ".id_bubble"},    pif.id_bubble,    frz);
        chk({tag, ".flush_front"},  pif.flush_front,  flush);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Reset with every trigger active.
        clr();
        rst = 1'b0;
        pif.mem_req = 1'b1;  pif.branch_taken = 1'b1;
        pif.exe_dest = 4'd3;  pif.exe_wb_en = 1'b1;  pif.exe_mem_read = 1'b1;
        pif.id_src1 = 4'd3;  pif.id_uses_src1 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst.outs", {pif.freeze_front, pif.id_bubble, pif.flush_front,
                             pif.freeze_all, pif.fwd_sel1, pif.fwd_sel2}, 0);
            chk("rst.stall_cnt", stall_cnt, 0);
        end
        clr();
        rst = 1'b1;
        #1;
        chk("idle.freeze_all", pif.freeze_all, 0);
        chk_front("idle", 0, 0);

        // SRAM stall: one mem_req pulse gives four frozen cycles.
        pif.mem_req = 1'b1;
        #1 chk("sram.fa0", pif.freeze_all, 1);
        step();
        pif.mem_req = 1'b0;
        for (int i = 1; i < 4; i++) begin
            #1 chk("sram.fa", pif.freeze_all, 1);
            chk("sram.cnt", stall_cnt, i);
            step();
        end
        #1 chk("sram.done_fa", pif.freeze_all, 0);
        chk("sram.stall_cnt", stall_cnt, 4);
        step();

        // Branch held through an SRAM stall; mem_req held into M_DONE.
        pif.mem_req = 1'b1;  pif.branch_taken = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1 chk("brsram.fa", pif.freeze_all, 1);
            chk("brsram.flush", pif.flush_front, 0);
            step();
        end
        #1 chk("brsram.done_fa", pif.freeze_all, 0);
        chk("brsram.done_flush", pif.flush_front, 1);
        chk("brsram.stall_cnt", stall_cnt, 8);
        clr();
        step();
        #1 chk("brsram.idle_fa", pif.freeze_all, 0);

        // RAW on src1 vs EXE, then branch on top of it.
        pif.exe_dest = 4'd3;  pif.exe_wb_en = 1'b1;
        pif.id_src1 = 4'd3;   pif.id_uses_src1 = 1'b1;
        #1 chk_front("raw", FWD ? 1'b0 : 1'b1, 0);
        pif.branch_taken = 1'b1;
        #1 chk_front("br_haz", 0, 1);
        pif.branch_taken = 1'b0;
        step();
        pif.exe_wb_en = 1'b0;
        #1 chk_front("raw_clear", 0, 0);

        // Load-use stalls in both builds; SRAM stall overrides it.
        pif.exe_wb_en = 1'b1;  pif.exe_mem_read = 1'b1;
        #1 chk_front("load_use", 1, 0);
        pif.mem_req = 1'b1;
        #1 chk("lu_sram.freeze_front", pif.freeze_front, 0);
        chk("lu_sram.freeze_all", pif.freeze_all, 1);
        step();
        pif.mem_req = 1'b0;
        step();  step();  step();
        #1 chk("lu_done.freeze_all", pif.freeze_all, 0);
        chk("lu_done.freeze_front", pif.freeze_front, 1);
        step();

        // R15 compared like any register; unused sources ignored.
        clr();
        pif.exe_dest = 4'hF;  pif.exe_wb_en = 1'b1;  pif.exe_mem_read = 1'b1;
        pif.id_src1 = 4'hF;   pif.id_uses_src1 = 1'b1;
        #1 chk_front("r15_src1", 1, 0);
        pif.id_uses_src1 = 1'b0;
        #1 chk_front("unused_src1", 0, 0);
        pif.id_src2 = 4'hF;  pif.id_two_src = 1'b1;
        #1 chk_front("r15_src2", 1, 0);
        pif.id_two_src = 1'b0;
        #1 chk_front("unused_src2", 0, 0);
        step();

        // Forwarding selects and priority.
        clr();
        pif.exe_dest = 4'd2;  pif.exe_wb_en = 1'b1;
        pif.id_src2 = 4'd2;   pif.id_two_src = 1'b1;
        #1 chk_front("fwd_exe", FWD ? 1'b0 : 1'b1, 0);
        chk("fwd_exe.sel2", pif.fwd_sel2, FWD ? 2'd1 : 2'd0);
        chk("fwd_exe.sel1", pif.fwd_sel1, 0);
        pif.exe_mem_read = 1'b1;
        #1 chk_front("fwd_load", 1, 0);
        pif.exe_mem_read = 1'b0;  pif.mem_dest = 4'd2;  pif.mem_wb_en = 1'b1;
        #1 chk("fwd_both.sel2", pif.fwd_sel2, FWD ? 2'd1 : 2'd0);
        pif.exe_wb_en = 1'b0;
        pif.id_src1 = 4'd2;  pif.id_uses_src1 = 1'b1;
        #1 chk("fwd_wb.sel2", pif.fwd_sel2, FWD ? 2'd2 : 2'd0);
        chk("fwd_wb.sel1", pif.fwd_sel1, FWD ? 2'd2 : 2'd0);
        chk_front("fwd_wb", FWD ? 1'b0 : 1'b1, 0);
        step();

        // Reset in the middle of an SRAM access aborts it.
        clr();
        pif.mem_req = 1'b1;
        step();
        pif.mem_req = 1'b0;
        step();
        rst = 1'b0;
        #1 chk("abort.rst_fa", pif.freeze_all, 0);
        step();
        rst = 1'b1;
        #1 chk("abort.fa", pif.freeze_all, 0);
        chk("abort.stall_cnt", stall_cnt, 0);
        step();
        #1 chk("abort.fa_next", pif.freeze_all, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
